// File: rtl/polaris_pkg.sv
// rtl/polaris_pkg.sv - shared types and defaults for the Polaris bus arbiter
package polaris_pkg;

    localparam int POLARIS_AW = 64;
    localparam int POLARIS_DW = 64;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'b00,
        ARB_OWN_I = 2'b01,
        ARB_OWN_D = 2'b10
    } arb_state_t;

endpackage

// File: rtl/polaris_arb_fsm.sv
// rtl/polaris_arb_fsm.sv - grant state machine; POLARIS_ARB_RR_EN selects round-robin IDLE ties
module polaris_arb_fsm
    import polaris_pkg::*;
(
    input  logic clk_i,
    input  logic reset_i,
    input  logic i_cyc_i,
    input  logic d_cyc_i,
    output logic own_i,
    output logic own_d
);

    arb_state_t state_q;
    arb_state_t state_d;
    logic       tie_to_d;

`ifdef POLARIS_ARB_RR_EN
    // Remembers which master held the bus most recently; reset value favours D.
    logic last_d_q;

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            last_d_q <= 1'b0;
        end else if (state_d != ARB_IDLE) begin
            last_d_q <= (state_d == ARB_OWN_D);
        end
    end

    assign tie_to_d = !last_d_q;
`else
    assign tie_to_d = 1'b1;
`endif

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE: begin
                if (i_cyc_i && d_cyc_i) begin
                    state_d = tie_to_d ? ARB_OWN_D : ARB_OWN_I;
                end else if (i_cyc_i) begin
                    state_d = ARB_OWN_I;
                end else if (d_cyc_i) begin
                    state_d = ARB_OWN_D;
                end
            end
            // Release hands straight to a waiting master, skipping IDLE.
            ARB_OWN_I: begin
                if (!i_cyc_i) begin
                    state_d = d_cyc_i ? ARB_OWN_D : ARB_IDLE;
                end
            end
            ARB_OWN_D: begin
                if (!d_cyc_i) begin
                    state_d = i_cyc_i ? ARB_OWN_I : ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    assign own_i = (state_q == ARB_OWN_I);
    assign own_d = (state_q == ARB_OWN_D);

endmodule

// File: rtl/polaris_bus_arbiter.sv
// rtl/polaris_bus_arbiter.sv - two-master Wishbone arbiter top (POLARIS_ARB_RR_EN honoured in polaris_arb_fsm)
module polaris_bus_arbiter
    import polaris_pkg::*;
#(
    parameter int AW = POLARIS_AW,
    parameter int DW = POLARIS_DW
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            i_cyc_i,
    input  logic            i_stb_i,
    input  logic [AW-1:0]   i_adr_i,
    output logic            i_ack_o,
    output logic [31:0]     i_dat_o,
    input  logic            d_cyc_i,
    input  logic            d_stb_i,
    input  logic            d_we_i,
    input  logic [DW/8-1:0] d_sel_i,
    input  logic [AW-1:0]   d_adr_i,
    input  logic [DW-1:0]   d_dat_i,
    output logic            d_ack_o,
    output logic [DW-1:0]   d_dat_o,
    output logic            m_cyc_o,
    output logic            m_stb_o,
    output logic            m_we_o,
    output logic [DW/8-1:0] m_sel_o,
    output logic [AW-1:0]   m_adr_o,
    output logic [DW-1:0]   m_dat_o,
    input  logic            m_ack_i,
    input  logic [DW-1:0]   m_dat_i
);

    logic own_i;
    logic own_d;
    logic act_i;
    logic act_d;

    polaris_arb_fsm u_fsm (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .i_cyc_i (i_cyc_i),
        .d_cyc_i (d_cyc_i),
        .own_i   (own_i),
        .own_d   (own_d)
    );

    // Owner still holding its cycle; gates both the slave request and the ack.
    assign act_i = own_i && i_cyc_i;
    assign act_d = own_d && d_cyc_i;

    always_comb begin
        m_cyc_o = 1'b0;
        m_stb_o = 1'b0;
        m_we_o  = 1'b0;
        m_sel_o = '0;
        m_adr_o = '0;
        m_dat_o = '0;
        if (act_i) begin
            m_cyc_o = 1'b1;
            m_stb_o = i_stb_i;
            m_sel_o = '1;
            m_adr_o = i_adr_i;
        end else if (act_d) begin
            m_cyc_o = 1'b1;
            m_stb_o = d_stb_i;
            m_we_o  = d_we_i;
            m_sel_o = d_sel_i;
            m_adr_o = d_adr_i;
            m_dat_o = d_dat_i;
        end
    end

    assign i_ack_o = act_i && m_ack_i;
    assign d_ack_o = act_d && m_ack_i;

    assign d_dat_o = own_d ? m_dat_i : '0;
    assign i_dat_o = !own_i    ? 32'h0 :
                     i_adr_i[2] ? m_dat_i[63:32] : m_dat_i[31:0];

endmodule
